crc16_frame_tx: RTL and testbench

Transmit-side partner of the byte-serial CRC16 checker. Accepts payload bytes from an upstream producer over a toggle handshake and computes CRC-CCITT over them bit-serially, MSB first. Forwards each byte to a downstream byte sink (UART/serial transmitter) over a toggle handshake. After the last payload byte it appends the 16-bit CRC, high byte first, so the far-end checker sees residue-consistent frames.

---
 rtl/crc16_pkg.sv | 27 ++
 rtl/crc16_frame_tx_if.sv | 22 ++
 rtl/crc16_shift_unit.sv | 63 ++++++
 rtl/crc16_frame_tx.sv | 133 +++++++++++++
 tb/tb_crc16_frame_tx.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crc16_pkg.sv
// Shared CRC-CCITT constants, FSM state encoding and the single-bit CRC step,
// common to the frame transmitter and the far-end checker.
package crc16_pkg;

    localparam logic [15:0] CRC_CCITT_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT       = 16'hFFFF;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        SHIFT     = 4'd1,
        SEND_DATA = 4'd2,
        WAIT_DATA = 4'd3,
        SEND_HI   = 4'd4,
        WAIT_HI   = 4'd5,
        SEND_LO   = 4'd6,
        WAIT_LO   = 4'd7,
        DONE      = 4'd8
    } tx_state_e;

    // One MSB-first CRC step: no reflection, x^16 implicit in the shift.
    function automatic logic [15:0] crc_step(input logic [15:0] crc,
                                             input logic        din,
                                             input logic [15:0] poly);
        return {crc[14:0], 1'b0} ^ ((din ^ crc[15]) ? poly : 16'h0000);
    endfunction

endpackage

// File: rtl/crc16_frame_tx_if.sv
// Producer/sink handshake bundle of crc16_frame_tx; master = bench/upstream side.
interface crc16_frame_tx_if;
    logic [7:0]  i_byte_in;
    logic        i_last;
    logic        i_take;
    logic        o_busy;
    logic [7:0]  o_byte_out;
    logic        o_send;
    logic        i_sent;
    logic [15:0] o_crc16;
    logic        o_frame_done;

    modport master (
        output i_byte_in, i_last, i_take, i_sent,
        input  o_busy, o_byte_out, o_send, o_crc16, o_frame_done
    );

    modport slave (
        input  i_byte_in, i_last, i_take, i_sent,
        output o_busy, o_byte_out, o_send, o_crc16, o_frame_done
    );
endinterface

// File: rtl/crc16_shift_unit.sv
// Bit-serial CRC engine: latches a byte, steps it MSB first into the CRC
// register and raises done one cycle after bit 0 has been absorbed.
module crc16_shift_unit
    import crc16_pkg::*;
#(
    parameter logic [15:0] POLYNOMIAL = CRC_CCITT_POLY,
    parameter logic [15:0] INIT_VALUE = CRC_INIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        load,
    input  logic        step,
    input  logic [7:0]  byte_in,
    output logic [7:0]  data,
    output logic [15:0] crc,
    output logic        done
);

    logic [15:0] crc_q, crc_d;
    logic [7:0]  byte_q, byte_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        done_q, done_d;

    always_comb begin
        crc_d  = crc_q;
        byte_d = byte_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        if (init) begin
            crc_d = INIT_VALUE;
        end
        if (load) begin
            byte_d = byte_in;
            cnt_d  = 3'd7;
            done_d = 1'b0;
        end else if (step && !done_q) begin
            // Steps after done are ignored so the FSM may dwell one extra cycle.
            crc_d  = crc_step(crc_q, byte_q[cnt_q], POLYNOMIAL);
            cnt_d  = cnt_q - 3'd1;
            done_d = (cnt_q == 3'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q  <= INIT_VALUE;
            byte_q <= 8'h00;
            cnt_q  <= 3'd7;
            done_q <= 1'b0;
        end else begin
            crc_q  <= crc_d;
            byte_q <= byte_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign data = byte_q;
    assign crc  = crc_q;
    assign done = done_q;

endmodule

// File: rtl/crc16_frame_tx.sv
// CRC16 frame transmitter: forwards payload bytes to a toggle-handshake sink
// and appends the CRC-CCITT (high byte first) after the last payload byte.
module crc16_frame_tx
    import crc16_pkg::*;
#(
    parameter logic [15:0] POLYNOMIAL = CRC_CCITT_POLY,
    parameter logic [15:0] INIT_VALUE = CRC_INIT
) (
    input  logic                   i_sys_clk,
    input  logic                   i_reset,
    crc16_frame_tx_if.slave        bus
);

    tx_state_e   state_q, state_d;
    logic        take_q, take_d;
    logic        sent_q, sent_d;
    logic        last_q, last_d;
    logic        send_q, send_d;
    logic [7:0]  byte_out_q, byte_out_d;

    logic        crc_init, crc_load, crc_step_en, crc_done;
    logic [7:0]  data;
    logic [15:0] crc;
    logic        ack;

    crc16_shift_unit #(
        .POLYNOMIAL (POLYNOMIAL),
        .INIT_VALUE (INIT_VALUE)
    ) u_shift (
        .clk     (i_sys_clk),
        .rst     (i_reset),
        .init    (crc_init),
        .load    (crc_load),
        .step    (crc_step_en),
        .byte_in (bus.i_byte_in),
        .data    (data),
        .crc     (crc),
        .done    (crc_done)
    );

    assign ack = (bus.i_sent != sent_q);

    always_comb begin
        state_d     = state_q;
        take_d      = take_q;
        sent_d      = sent_q;
        last_d      = last_q;
        send_d      = send_q;
        byte_out_d  = byte_out_q;
        crc_init    = 1'b0;
        crc_load    = 1'b0;
        crc_step_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Stray acks while idle are absorbed so they cannot release a later wait.
                sent_d = bus.i_sent;
                if (bus.i_take != take_q) begin
                    take_d   = bus.i_take;
                    last_d   = bus.i_last;
                    crc_load = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                crc_step_en = 1'b1;
                if (crc_done) state_d = SEND_DATA;
            end
            SEND_DATA: begin
                byte_out_d = data;
                send_d     = ~send_q;
                state_d    = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (ack) begin
                    sent_d  = bus.i_sent;
                    state_d = last_q ? SEND_HI : IDLE;
                end
            end
            SEND_HI: begin
                byte_out_d = crc[15:8];
                send_d     = ~send_q;
                state_d    = WAIT_HI;
            end
            WAIT_HI: begin
                if (ack) begin
                    sent_d  = bus.i_sent;
                    state_d = SEND_LO;
                end
            end
            SEND_LO: begin
                byte_out_d = crc[7:0];
                send_d     = ~send_q;
                state_d    = WAIT_LO;
            end
            WAIT_LO: begin
                if (ack) begin
                    sent_d  = bus.i_sent;
                    state_d = DONE;
                end
            end
            DONE: begin
                crc_init = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            take_q     <= 1'b0;
            sent_q     <= 1'b0;
            last_q     <= 1'b0;
            send_q     <= 1'b0;
            byte_out_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            take_q     <= take_d;
            sent_q     <= sent_d;
            last_q     <= last_d;
            send_q     <= send_d;
            byte_out_q <= byte_out_d;
        end
    end

    assign bus.o_busy       = (state_q != IDLE);
    assign bus.o_frame_done = (state_q == DONE);
    assign bus.o_byte_out   = byte_out_q;
    assign bus.o_send       = send_q;
    assign bus.o_crc16      = crc;

endmodule

// File: tb/tb_crc16_frame_tx.sv
// Scoreboard bench for crc16_frame_tx: producer pushes expected sink bytes,
// a toggle-ack sink model pops and compares every emitted byte.
module tb_crc16_frame_tx;

    logic clk;
    logic rst;
    crc16_frame_tx_if bus();

    crc16_frame_tx dut (
        .i_sys_clk (clk),
        .i_reset   (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] model_crc = 16'hFFFF;
    int          rx_count = 0;
    int          ack_delay = 3;
    int          stall_idx = -1;
    logic [15:0] rx_crc = 16'h0000;
    int          done_count = 0;

    function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (b[i] ^ r[15]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    // Sink: compares each emitted byte with the scoreboard, then acks after a delay.
    initial begin
        logic       send_seen;
        logic [7:0] exp_b;
        int         d;
        send_seen  = 1'b0;
        bus.i_sent = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                send_seen  = 1'b0;
                bus.i_sent = 1'b0;
            end else if (bus.o_send !== send_seen) begin
                send_seen = bus.o_send;
                rx_crc    = bus.o_crc16;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sink_byte: got %h, required no byte", bus.o_byte_out);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (bus.o_byte_out !== exp_b) begin
                        errors++;
                        $display("FAIL sink_byte[%0d]: got %h, required %h", rx_count, bus.o_byte_out, exp_b);
                    end
                end
                d = (rx_count == stall_idx) ? 50 : ack_delay;
                rx_count++;
                repeat (d) @(negedge clk);
                if (!rst) bus.i_sent = ~bus.i_sent;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.o_frame_done === 1'b1) done_count++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.o_busy === 1'b1 && n < 2000);
        checks++;
        if (bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: o_busy %b after %0d cycles, required 0", name, bus.o_busy, n);
        end
    endtask

    task automatic offer(input logic [7:0] b, input logic last);
        wait_idle("offer_idle");
        bus.i_byte_in = b;
        bus.i_last    = last;
        exp_q.push_back(b);
        model_crc = ref_crc(model_crc, b);
        if (last) begin
            exp_q.push_back(model_crc[15:8]);
            exp_q.push_back(model_crc[7:0]);
            model_crc = 16'hFFFF;
        end
        bus.i_take = ~bus.i_take;
    endtask

    task automatic offer_check_123(input bit last_on_9);
        for (int i = 1; i <= 9; i++)
            offer(8'h30 + 8'(i), (i == 9) && last_on_9);
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_byte_out !== 8'h00 || bus.o_send !== 1'b0 ||
            bus.o_frame_done !== 1'b0 || bus.o_crc16 !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_values: busy=%b byte=%h send=%b done=%b crc=%h, required 0 00 0 0 ffff",
                     bus.o_busy, bus.o_byte_out, bus.o_send, bus.o_frame_done, bus.o_crc16);
        end
    endtask

    task automatic test_single_byte;
        int base_rx, base_done;
        ack_delay = 3;
        base_rx   = rx_count;
        base_done = done_count;
        offer(8'h41, 1'b1);
        wait_idle("single_idle");
        checks++;
        if (rx_crc !== 16'hB915) begin
            errors++;
            $display("FAIL single_crc: got %h, required b915", rx_crc);
        end
        checks++;
        if (rx_count - base_rx != 3) begin
            errors++;
            $display("FAIL single_count: got %0d bytes, required 3", rx_count - base_rx);
        end
        checks++;
        if (done_count - base_done != 1) begin
            errors++;
            $display("FAIL single_done: got %0d pulses, required 1", done_count - base_done);
        end
    endtask

    task automatic test_check_string;
        int base_rx;
        ack_delay = 2;
        base_rx   = rx_count;
        offer_check_123(1'b1);
        wait_idle("string_idle");
        checks++;
        if (rx_crc !== 16'h29B1) begin
            errors++;
            $display("FAIL string_crc: got %h, required 29b1", rx_crc);
        end
        checks++;
        if (rx_count - base_rx != 11) begin
            errors++;
            $display("FAIL string_count: got %0d bytes, required 11", rx_count - base_rx);
        end
    endtask

    task automatic test_latency;
        logic s0, busy_bad, busy11;
        int   lat;
        ack_delay = 0;
        wait_idle("lat_pre");
        s0       = bus.o_send;
        lat      = -1;
        busy_bad = 1'b0;
        busy11   = 1'b1;
        offer(8'h5A, 1'b0);
        for (int k = 0; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (k <= 10 && bus.o_busy !== 1'b1) busy_bad = 1'b1;
            if (lat < 0 && bus.o_send !== s0) lat = k;
            if (k == 11) busy11 = bus.o_busy;
        end
        checks++;
        if (lat != 10) begin
            errors++;
            $display("FAIL latency: o_send toggled at edge %0d, required 10", lat);
        end
        checks++;
        if (busy_bad !== 1'b0) begin
            errors++;
            $display("FAIL latency_busy: o_busy dropped before ack, required high edges 0..10");
        end
        checks++;
        if (busy11 !== 1'b0) begin
            errors++;
            $display("FAIL latency_release: o_busy %b at edge 11, required 0", busy11);
        end
        offer(8'hA5, 1'b1);
        wait_idle("lat_post");
    endtask

    task automatic test_back_to_back;
        int base_done;
        ack_delay = 1;
        base_done = done_count;
        offer(8'h41, 1'b1);
        offer(8'h00, 1'b1);
        wait_idle("b2b_idle");
        checks++;
        if (rx_crc !== 16'hE1F0) begin
            errors++;
            $display("FAIL b2b_crc: got %h, required e1f0", rx_crc);
        end
        checks++;
        if (done_count - base_done != 2) begin
            errors++;
            $display("FAIL b2b_done: got %0d pulses, required 2", done_count - base_done);
        end
    endtask

    task automatic test_reset_mid_frame;
        int base_rx;
        ack_delay = 1;
        offer(8'h31, 1'b0);
        offer(8'h32, 1'b0);
        offer(8'h33, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_byte_out !== 8'h00 || bus.o_send !== 1'b0 ||
            bus.o_frame_done !== 1'b0 || bus.o_crc16 !== 16'hFFFF) begin
            errors++;
            $display("FAIL midreset_values: busy=%b byte=%h send=%b done=%b crc=%h, required 0 00 0 0 ffff",
                     bus.o_busy, bus.o_byte_out, bus.o_send, bus.o_frame_done, bus.o_crc16);
        end
        exp_q.delete();
        model_crc  = 16'hFFFF;
        bus.i_take = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base_rx = rx_count;
        offer(8'h41, 1'b1);
        wait_idle("midreset_idle");
        repeat (5) @(negedge clk);
        checks++;
        if (rx_count - base_rx != 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_count: got %0d bytes (%0d pending), required 3 (0)",
                     rx_count - base_rx, exp_q.size());
        end
        checks++;
        if (rx_crc !== 16'hB915) begin
            errors++;
            $display("FAIL midreset_crc: got %h, required b915", rx_crc);
        end
    endtask

    task automatic test_sink_stall;
        int   base_rx, n, held_rx;
        logic lvl, bad;
        ack_delay = 1;
        base_rx   = rx_count;
        stall_idx = base_rx + 9;
        offer_check_123(1'b1);
        n = 0;
        while (rx_count < base_rx + 10 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rx_count < base_rx + 10) begin
            errors++;
            $display("FAIL stall_reach: got %0d bytes, required 10", rx_count - base_rx);
        end
        @(negedge clk);
        lvl     = bus.o_send;
        held_rx = rx_count;
        bad     = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.o_byte_out !== 8'h29 || bus.o_send !== lvl || rx_count != held_rx) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: byte=%h send=%b, required 29 held at %b", bus.o_byte_out, bus.o_send, lvl);
        end
        wait_idle("stall_idle");
        stall_idx = -1;
        checks++;
        if (rx_count - base_rx != 11) begin
            errors++;
            $display("FAIL stall_count: got %0d bytes, required 11", rx_count - base_rx);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.i_byte_in = 8'h00;
        bus.i_last    = 1'b0;
        bus.i_take    = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_single_byte();
        test_check_string();
        test_latency();
        test_back_to_back();
        test_reset_mid_frame();
        test_sink_stall();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d bytes pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
